// File: rtl/db4_pkg.sv
// Shared constants for the Daubechies-4 polyphase analysis stage:
// fixed filter taps (x256), accumulator sizing and rounding-mode codes.
package db4_pkg;

  localparam int COEF_W = 9;

  localparam logic signed [COEF_W-1:0] H0 = 9'sd124;
  localparam logic signed [COEF_W-1:0] H1 = 9'sd214;
  localparam logic signed [COEF_W-1:0] H2 = 9'sd57;
  localparam logic signed [COEF_W-1:0] H3 = -9'sd33;

  // Quadrature mirror of the lowpass taps: g[k] = (-1)^k * h[3-k]
  localparam logic signed [COEF_W-1:0] G0 = -9'sd33;
  localparam logic signed [COEF_W-1:0] G1 = -9'sd57;
  localparam logic signed [COEF_W-1:0] G2 = 9'sd214;
  localparam logic signed [COEF_W-1:0] G3 = -9'sd124;

  localparam int RND_TRUNC   = 0;
  localparam int RND_HALF_UP = 1;

  // sum(|h|) = 428 < 2^9, plus one sign bit of headroom
  function automatic int acc_width(input int w_in);
    return w_in + 10;
  endfunction

endpackage

// File: rtl/db4_round_sat.sv
// Scales one channel's accumulator down to the output width:
// optional half-up rounding, arithmetic shift, then saturate or wrap.
module db4_round_sat
  import db4_pkg::*;
#(
  parameter int W_ACC = 18,
  parameter int SHIFT = 8,
  parameter int W_OUT = 9,
  parameter int ROUND = RND_TRUNC,
  parameter int SAT   = 0
) (
  input  logic signed [W_ACC-1:0] acc,
  output logic signed [W_OUT-1:0] y,
  output logic                    ovf
);

  // One extra bit so the rounding bias can never wrap the sum
  localparam int WS = W_ACC + 1;
  localparam int RB = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [WS-1:0] RBIAS =
    (ROUND == RND_HALF_UP && SHIFT > 0) ? WS'(64'sd1 <<< RB) : '0;
  localparam logic signed [WS-1:0] YMAX = WS'((64'sd1 <<< (W_OUT-1)) - 64'sd1);
  localparam logic signed [WS-1:0] YMIN = WS'(-(64'sd1 <<< (W_OUT-1)));

  logic signed [WS-1:0] rnd, sh;

  always_comb begin
    rnd = WS'(acc) + RBIAS;
    sh  = rnd >>> SHIFT;
    ovf = (sh > YMAX) || (sh < YMIN);
    if (SAT != 0 && ovf) y = sh[WS-1] ? YMIN[W_OUT-1:0] : YMAX[W_OUT-1:0];
    else                 y = sh[W_OUT-1:0];
  end

endmodule

// File: rtl/db4poly_dec.sv
// Single-clock Daubechies-4 decimate-by-2 analysis stage. A phase bit splits
// the qualified stream into even/odd samples; each odd sample launches a pair.
module db4poly_dec
  import db4_pkg::*;
#(
  parameter int W_IN  = 8,
  parameter int W_OUT = 9,
  parameter int SHIFT = 8,
  parameter int ROUND = RND_TRUNC,
  parameter int SAT   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [W_IN-1:0]  x_in,
  input  logic                    x_valid,
  input  logic                    sync,
  output logic signed [W_OUT-1:0] y_lo,
  output logic signed [W_OUT-1:0] y_hi,
  output logic                    y_valid,
  output logic                    ovf,
  output logic                    phase
);

  localparam int W_ACC  = acc_width(W_IN);
  localparam int STAGES = 2;
  localparam int NTAP   = 4;

  logic [STAGES:0]             vld_pipe;
  logic signed [W_IN-1:0]      x_even, cur_e, cur_o, hist_e, hist_o;
  logic [NTAP-1:0][W_ACC-1:0]  p_lo, p_hi;
  logic [1:0][W_ACC-1:0]       acc;
  logic [1:0][W_OUT-1:0]       y_rs;
  logic [1:0]                  ovf_rs;
  logic                        launch;

  // Constant multiply by one of the fixed taps using shifts and adds only
  function automatic logic signed [W_ACC-1:0] cmul(input logic signed [W_ACC-1:0] x,
                                                   input logic signed [COEF_W-1:0] c);
    logic signed [W_ACC-1:0] r;
    case (c)
      9'sd124:  r = (x <<< 7) - (x <<< 2);
      -9'sd124: r = (x <<< 2) - (x <<< 7);
      9'sd214:  r = (x <<< 8) - (x <<< 5) - (x <<< 3) - (x <<< 1);
      -9'sd214: r = (x <<< 5) + (x <<< 3) + (x <<< 1) - (x <<< 8);
      9'sd57:   r = (x <<< 6) - (x <<< 3) + x;
      -9'sd57:  r = (x <<< 3) - (x <<< 6) - x;
      9'sd33:   r = (x <<< 5) + x;
      -9'sd33:  r = -((x <<< 5) + x);
      default:  r = '0;
    endcase
    return r;
  endfunction

  // sync forces the current sample (if any) to be x[0]
  assign launch  = x_valid & phase & ~sync;
  assign y_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase  <= 1'b0;
      x_even <= '0;
      cur_e  <= '0;
      cur_o  <= '0;
      hist_e <= '0;
      hist_o <= '0;
    end else if (sync) begin
      phase  <= x_valid;
      x_even <= x_valid ? x_in : '0;
      cur_e  <= '0;
      cur_o  <= '0;
      hist_e <= '0;
      hist_o <= '0;
    end else if (x_valid) begin
      phase <= ~phase;
      if (!phase) begin
        x_even <= x_in;
      end else begin
        hist_e <= cur_e;
        hist_o <= cur_o;
        cur_e  <= x_even;
        cur_o  <= x_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], launch};
  end

  // Stage 1: products of the launched pair and its one-pair history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_lo <= '0;
      p_hi <= '0;
    end else begin
      p_lo[0] <= cmul(W_ACC'(cur_o),  H0);
      p_lo[1] <= cmul(W_ACC'(cur_e),  H1);
      p_lo[2] <= cmul(W_ACC'(hist_o), H2);
      p_lo[3] <= cmul(W_ACC'(hist_e), H3);
      p_hi[0] <= cmul(W_ACC'(cur_o),  G0);
      p_hi[1] <= cmul(W_ACC'(cur_e),  G1);
      p_hi[2] <= cmul(W_ACC'(hist_o), G2);
      p_hi[3] <= cmul(W_ACC'(hist_e), G3);
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NTAP; i++) begin
      acc[0] = acc[0] + p_lo[i];
      acc[1] = acc[1] + p_hi[i];
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    db4_round_sat #(
      .W_ACC(W_ACC), .SHIFT(SHIFT), .W_OUT(W_OUT), .ROUND(ROUND), .SAT(SAT)
    ) u_rs (
      .acc (acc[ch]),
      .y   (y_rs[ch]),
      .ovf (ovf_rs[ch])
    );
  end

  // Stage 2: values hold between strobes, ovf is a strobe companion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_lo <= '0;
      y_hi <= '0;
      ovf  <= 1'b0;
    end else begin
      ovf <= vld_pipe[STAGES-1] & (|ovf_rs);
      if (vld_pipe[STAGES-1]) begin
        y_lo <= y_rs[0];
        y_hi <= y_rs[1];
      end
    end
  end

endmodule

// File: tb/tb_db4poly_dec.sv
// Scoreboard bench for db4poly_dec: four configurations share one stimulus
// stream; a reference model predicts each pair, a forked monitor checks them.
module tb_db4poly_dec;

  localparam int NC = 4;

  function automatic int cw(input int k); return (k >= 2) ? 8 : 9; endfunction
  function automatic int cr(input int k); return (k == 1) ? 1 : 0; endfunction
  function automatic int cs(input int k); return (k == 2) ? 1 : 0; endfunction

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [7:0] x_in = '0;
  logic              x_valid = 1'b0;
  logic              sync = 1'b0;

  logic signed [31:0] ylo [NC];
  logic signed [31:0] yhi [NC];
  logic               yv  [NC];
  logic               yo  [NC];
  logic               yp  [NC];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < NC; k++) begin : g_dut
    localparam int WO = cw(k);
    logic signed [WO-1:0] lo, hi;
    logic v, o, p;
    db4poly_dec #(.W_IN(8), .W_OUT(WO), .SHIFT(8), .ROUND(cr(k)), .SAT(cs(k))) u_dut (
      .clk(clk), .reset(rst_n), .x_in(x_in), .x_valid(x_valid), .sync(sync),
      .y_lo(lo), .y_hi(hi), .y_valid(v), .ovf(o), .phase(p)
    );
    assign ylo[k] = 32'(lo);
    assign yhi[k] = 32'(hi);
    assign yv[k]  = v;
    assign yo[k]  = o;
    assign yp[k]  = p;
  end

  typedef struct { longint lo; longint hi; int due; } exp_t;
  typedef struct { int k; int lo; int hi; bit ov; } log_t;

  int   hc [4] = '{124, 214, 57, -33};
  int   gc [4] = '{-33, -57, 214, -124};
  exp_t exp_q[$];
  log_t log_q[$];
  int   smp[$];
  int   rd [NC] = '{0, 0, 0, 0};
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic longint xs(input int i);
    return (i < 0) ? 0 : longint'(smp[i]);
  endfunction

  // Accept one sample into the model; a completed pair yields raw x256 sums
  task automatic model_accept(input int x, input bit s, input int cap);
    longint lo, hi;
    int m;
    if (s) smp.delete();
    smp.push_back(x);
    if (smp.size() % 2 == 0) begin
      m = smp.size() / 2 - 1;
      lo = 0;
      hi = 0;
      for (int t = 0; t < 4; t++) begin
        lo += hc[t] * xs(2*m + 1 - t);
        hi += gc[t] * xs(2*m + 1 - t);
      end
      exp_q.push_back('{lo, hi, cap + 2});
    end
  endtask

  // Scale a raw sum as configuration k defines: floor(/256), clamp or wrap
  function automatic int xform(input longint s, input int k, output bit of);
    longint d, q, mx, mn, md;
    d = s + (cr(k) != 0 ? 128 : 0);
    q = d / 256;
    if ((d % 256 != 0) && d < 0) q = q - 1;
    mx = (longint'(1) << (cw(k) - 1)) - 1;
    mn = -mx - 1;
    of = (q > mx) || (q < mn);
    if (!of) return int'(q);
    if (cs(k) != 0) return int'((q > mx) ? mx : mn);
    md = mx - mn + 1;
    q = ((q % md) + md) % md;
    if (q > mx) q = q - md;
    return int'(q);
  endfunction

  task automatic monitor();
    exp_t e;
    int wl, wh;
    bit ol, oh;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NC; k++) begin
        if (yv[k]) begin
          if (rd[k] >= exp_q.size()) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid dut%0d: got y_valid=1 expected no pending pair", k);
          end else begin
            e = exp_q[rd[k]];
            rd[k]++;
            wl = xform(e.lo, k, ol);
            wh = xform(e.hi, k, oh);
            chk($sformatf("y_lo dut%0d", k), ylo[k], wl);
            chk($sformatf("y_hi dut%0d", k), yhi[k], wh);
            chk($sformatf("ovf dut%0d", k), yo[k], ol | oh);
            chk($sformatf("latency dut%0d", k), cyc, e.due);
            log_q.push_back('{k, int'(ylo[k]), int'(yhi[k]), yo[k]});
          end
        end
      end
    end
  endtask

  task automatic send(input int x, input bit v, input bit s);
    @(negedge clk);
    x_in = 8'(x);
    x_valid = v;
    sync = s;
    if (v) model_accept(x, s, cyc + 1);
    else if (s) smp.delete();
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    sync = 1'b0;
  endtask

  // Known-answer check on the n-th logged pair of one configuration
  task automatic kat(input string name, input int k, input int n, input int lo, input int hi);
    int seen;
    bit found;
    seen = 0;
    found = 1'b0;
    foreach (log_q[i]) begin
      if (log_q[i].k == k) begin
        if (seen == n && !found) begin
          found = 1'b1;
          chk({name, "_lo"}, log_q[i].lo, lo);
          chk({name, "_hi"}, log_q[i].hi, hi);
        end
        seen++;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d pairs expected pair index %0d", name, seen, n);
    end
  endtask

  task automatic kat_last(input string name, input int k, input int lo, input int hi, input bit ov);
    bit found;
    log_t l;
    found = 1'b0;
    foreach (log_q[i]) if (log_q[i].k == k) begin found = 1'b1; l = log_q[i]; end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: got no pairs expected at least one", name);
    end else begin
      chk({name, "_lo"}, l.lo, lo);
      chk({name, "_hi"}, l.hi, hi);
      chk({name, "_ovf"}, l.ov, ov);
    end
  endtask

  task automatic check_zero(input string name);
    for (int k = 0; k < NC; k++) begin
      chk($sformatf("%s y_lo dut%0d", name, k), ylo[k], 0);
      chk($sformatf("%s y_hi dut%0d", name, k), yhi[k], 0);
      chk($sformatf("%s y_valid dut%0d", name, k), yv[k], 0);
      chk($sformatf("%s ovf dut%0d", name, k), yo[k], 0);
      chk($sformatf("%s phase dut%0d", name, k), yp[k], 0);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // impulse at x[0], back to back
    log_q.delete();
    send(100, 1, 0);
    repeat (7) send(0, 1, 0);
    repeat (4) send(0, 0, 0);
    kat("imp0_p0", 0, 0, 83, -23);
    kat("imp0_p1", 0, 1, -13, -49);
    kat("imp0_rnd_p0", 1, 0, 84, -22);
    kat("imp0_rnd_p1", 1, 1, -13, -48);

    // impulse at x[1]
    send(0, 0, 1);
    log_q.delete();
    send(0, 1, 0);
    send(100, 1, 0);
    repeat (6) send(0, 1, 0);
    repeat (4) send(0, 0, 0);
    kat("imp1_p0", 0, 0, 48, -13);
    kat("imp1_p1", 0, 1, 22, 83);

    // DC, full rate
    send(0, 0, 1);
    log_q.delete();
    repeat (40) send(127, 1, 0);
    repeat (4) send(0, 0, 0);
    kat_last("dc127", 0, 179, 0, 0);
    kat_last("dc127_rnd", 1, 180, 0, 0);
    kat_last("dc127_w8sat", 2, 127, 0, 1);
    kat_last("dc127_w8wrap", 3, -77, 0, 1);

    send(0, 0, 1);
    log_q.delete();
    repeat (20) send(-128, 1, 0);
    repeat (4) send(0, 0, 0);
    kat_last("dcm128", 0, -181, 0, 0);

    // gapped impulse
    send(0, 0, 1);
    log_q.delete();
    send(100, 1, 0);
    repeat (7) begin
      repeat ($urandom_range(0, 3)) send(0, 0, 0);
      send(0, 1, 0);
    end
    repeat (4) send(0, 0, 0);
    kat("gap_p0", 0, 0, 83, -23);
    kat("gap_p1", 0, 1, -13, -49);

    // sync between even and odd sample
    send(0, 0, 1);
    log_q.delete();
    send(55, 1, 0);
    chk("phase_after_even", yp[0], 1);
    send(0, 0, 1);
    chk("phase_after_sync", yp[0], 0);
    send(100, 1, 0);
    send(0, 1, 0);
    repeat (4) send(0, 0, 0);
    kat("sync_mid", 0, 0, 83, -23);

    // sync together with a sample
    log_q.delete();
    send(77, 1, 0);
    send(100, 1, 1);
    chk("phase_sync_valid", yp[0], 1);
    send(0, 1, 0);
    repeat (4) send(0, 0, 0);
    kat("sync_valid", 0, 0, 83, -23);

    // random stream with gaps and occasional realign
    send(0, 0, 1);
    repeat (300) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 4)       send(0, 0, 0);
      else if (r == 4) send(0, 0, 1);
      else             send($urandom_range(0, 255) - 128, 1, r == 5);
    end
    repeat (5) send(0, 0, 0);

    // reset while a pair is in flight
    send(0, 0, 1);
    send(20, 1, 0);
    send(40, 1, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < NC; k++) rd[k] = exp_q.size();
    smp.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_zero("midreset");

    for (int k = 0; k < NC; k++)
      chk($sformatf("drained dut%0d", k), rd[k], exp_q.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/db4poly_dec.md
Name: db4poly_dec

Overview:
- Parametrised single-clock successor to the Daubechies-4 polyphase decimator.
- Accepts a qualified sample stream and splits it into even/odd phases internally using a phase bit. No derived clock is used.
- Produces both decimated-by-2 analysis outputs: the lowpass approximation and the highpass detail.
- Sits at the front of the DWT analysis chain. Instances can cascade for multi-level decomposition because y_valid can feed the next stage's x_valid.

Parameters:
- W_IN, 8: signed input sample width.
- W_OUT, 9: signed output width of each channel.
- SHIFT, 8: right-shift applied to the accumulator. Coefficients are scaled by 256.
- ROUND, 0: 0 = truncate (floor, arithmetic shift); 1 = round half up (add 2^(SHIFT-1) before shifting).
- SAT, 0: 0 = wrap on output overflow; 1 = saturate to W_OUT limits.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- x_in, in, W_IN: signed input sample.
- x_valid, in, 1: x_in is consumed on every clk edge where x_valid is high. There is no backpressure.
- sync, in, 1: synchronous stream realign. It clears the phase bit and the sample history.
- y_lo, out, W_OUT: lowpass (approximation) output, registered.
- y_hi, out, W_OUT: highpass (detail) output, registered.
- y_valid, out, 1: one-cycle strobe qualifying y_lo and y_hi.
- ovf, out, 1: high together with y_valid when either channel overflowed W_OUT. It is reported whether the result was saturated or wrapped.
- phase, out, 1: test output. 0 = next accepted sample is even, 1 = next is odd.

Behaviour:
- Coefficients are fixed and signed, 9 bits.
  - Lowpass: h0..h3 = 124, 214, 57, -33.
  - Highpass: g0..g3 = -33, -57, 214, -124, where gk = (-1)^k h(3-k).
- Sample numbering: after reset or sync, the first accepted sample is x[0] (even).
- Output pair m is formed once x[2m+1] is accepted:
  - ylo[m] = h0 x[2m+1] + h1 x[2m] + h2 x[2m-1] + h3 x[2m-2]
  - yhi[m] = same formula with the g coefficients.
  - Samples before x[0] are taken as 0.
- Phase bit:
  - Toggles on each accepted sample.
  - Even sample: stored in an even register.
  - Odd sample: launches the pair computation, and shifts the current pair into a one-pair history.
- Pipeline:
  - Stage 1 registers the 8 products. Multipliers are shift-add constants; no generic multipliers.
  - Stage 2 registers the sum, the round/shift and the saturate/wrap result.
  - Latency: if the odd sample is captured on edge t, then y_lo, y_hi and y_valid update on edge t+2.
  - Full throughput: x_valid may be high every cycle, giving y_valid every second cycle.
- Accumulator width: W_ACC = W_IN + 10. This guarantees no internal overflow, since the sum of |h| is 428 < 2^9.
- Rounding: applied before the shift.
- Saturation: clamps to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
- Wrap mode: keeps the low W_OUT bits of the shifted sum.
- Reset (active low, asynchronous, any time including mid-pipeline):
  - y_lo, y_hi = 0; y_valid = 0; ovf = 0; phase = 0.
  - Even register, history and pipeline registers are all cleared.
  - In-flight results are discarded.
- sync:
  - Clears phase and history on the next edge.
  - Pipeline results already in flight still emit normally.
  - If sync and x_valid are high in the same cycle, the sample is accepted as the new x[0].
- x_valid low: state holds and y_valid stays low, except for in-flight results.
- Outputs hold their last value while y_valid is low.

Decomposition:
- Package db4_pkg holds:
  - Coefficient constants H0..H3 and G0..G3.
  - COEF_W = 9.
  - Function acc_width(W_IN).
  - Round-mode encodings.
- Sub-module db4_round_sat, instantiated once per channel. It is combinational and parametrised by W_ACC, SHIFT, W_OUT, ROUND and SAT. It outputs the value and an overflow flag.

Test Plan:
- Defaults, impulse x[0]=100 then zeros:
  - First pair: y_lo=83, y_hi=-23.
  - Second pair: y_lo=-13, y_hi=-49.
  - With ROUND=1: 84, -22, then -13, -48.
- Impulse at x[1]=100: first pair y_lo=48; second pair y_lo=22. Check y_valid exactly 2 edges after x[1] is captured.
- DC x=127 continuous with x_valid high every cycle:
  - Steady state y_lo=179 (ROUND=1: 180), y_hi=0.
  - y_valid strobes every other cycle, ovf=0.
- DC x=127 with W_OUT=8: SAT=1 gives y_lo=127, ovf=1; SAT=0 gives y_lo=-77, ovf=1. DC x=-128 with defaults gives y_lo=-181.
- Gapped x_valid (random idle cycles) repeating the impulse test: identical output values, and only the y_valid timing shifts.
- Control events:
  - sync asserted between the even and odd sample: phase returns to 0, and the next sample becomes x[0].
  - Reset pulsed low one cycle after an odd sample: y_valid never fires, and all outputs read 0.
